// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at a time,
// buffers returned words in a small FIFO and flushes it on a taken branch.
module fetch_unit #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PCSrc_i,
  input  logic [ADDR_WIDTH-1:0]  PCTarget_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pcplus4_o,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_ready_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [ADDR_WIDTH-1:0]   req_pc;
  logic [CNT_W-1:0]        count;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [ADDR_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0]  instr_mem [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^PCTarget_i[1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next state, request and push decode; a redirect masks both request and push
  always_comb begin
    state_next = state;
    imem_req_o = 1'b0;
    push       = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_o = (count < CNT_W'(DEPTH)) && !PCSrc_i && !rst;
        if (imem_req_o && imem_ready_i) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_next = S_FETCH;
          push       = !PCSrc_i;
        end else if (PCSrc_i) begin
          state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid_i) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign issue = imem_req_o && imem_ready_i;
  assign pop   = valid_o && ready_i && !PCSrc_i;

  // PC and FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (PCSrc_i) begin
      fetch_pc <= {PCTarget_i[ADDR_WIDTH-1:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_rdata_i;
    end
  end

  assign valid_o     = (count != '0);
  assign instr_o     = valid_o ? instr_mem[rd_ptr] : NOP;
  assign pc_o        = valid_o ? pc_mem[rd_ptr] : '0;
  assign pcplus4_o   = pc_o + ADDR_WIDTH'(4);
  assign imem_addr_o = fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-accurate vector table plus
// hand-written sequences driven through a simple latency-configurable memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc_i;
  logic [31:0] PCTarget_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrc_i       (PCSrc_i),
    .PCTarget_i    (PCTarget_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pcplus4_o     (pcplus4_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        pcsrc;
    logic [31:0] tgt;
    logic        rdy;
    logic        mrdy;
    logic        rv;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
  } pop_t;

  vec_t tbl[19];
  pop_t pops[$];

  // Bench-side memory model and per-cycle stimulus
  bit          m_busy = 0;
  int          m_cnt  = 0;
  int          m_lat  = 1;
  bit          m_ready = 1;
  logic [31:0] m_addr = '0;
  bit          t_rst = 1, t_pcsrc = 0, t_ready = 1;
  logic [31:0] t_target = '0;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    rst           = t_rst;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = tag(m_addr);
        m_busy        = 0;
      end
    end
    imem_ready_i = m_ready;
    ready_i      = t_ready;
    PCSrc_i      = t_pcsrc;
    PCTarget_i   = t_target;
    #1;
    if (imem_req_o && imem_ready_i) begin
      m_busy = 1;
      m_cnt  = m_lat;
      m_addr = imem_addr_o;
    end
    if (valid_o && ready_i && !PCSrc_i) pops.push_back('{pc_o, instr_o, pcplus4_o});
  endtask

  task automatic collect(input int n, input string name);
    for (int c = 0; c < 80 && pops.size() < n; c++) run_cycle();
    chk({name, "_popcount"}, 32'(pops.size()), 32'(n));
  endtask

  task automatic chk_pop(input int idx, input logic [31:0] exp_pc, input string name);
    if (idx < pops.size()) begin
      chk({name, "_pc"}, pops[idx].pc, exp_pc);
      chk({name, "_instr"}, pops[idx].instr, tag(exp_pc));
      chk({name, "_pcplus4"}, pops[idx].p4, exp_pc + 32'd4);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, 32'(valid_o), 32'd0);
    chk({name, "_instr"}, instr_o, NOP);
    chk({name, "_pc"}, pc_o, 32'd0);
    chk({name, "_req"}, 32'(imem_req_o), 32'd0);
    chk({name, "_addr"}, imem_addr_o, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //          pcsrc tgt         rdy mrdy rv rdata          valid instr          pc          req addr
    tbl[0]  = '{0, 32'h0,   1, 1, 0, 32'h0,          0, NOP,           32'h0,   1, 32'h0};
    tbl[1]  = '{0, 32'h0,   1, 1, 1, 32'hAAAA_0000,  0, NOP,           32'h0,   0, 32'h4};
    tbl[2]  = '{0, 32'h0,   0, 1, 0, 32'h0,          1, 32'hAAAA_0000, 32'h0,   1, 32'h4};
    tbl[3]  = '{0, 32'h0,   0, 1, 1, 32'hBBBB_0004,  1, 32'hAAAA_0000, 32'h0,   0, 32'h8};
    tbl[4]  = '{0, 32'h0,   0, 1, 0, 32'h0,          1, 32'hAAAA_0000, 32'h0,   0, 32'h8};
    tbl[5]  = '{0, 32'h0,   1, 1, 0, 32'h0,          1, 32'hAAAA_0000, 32'h0,   0, 32'h8};
    tbl[6]  = '{0, 32'h0,   0, 0, 0, 32'h0,          1, 32'hBBBB_0004, 32'h4,   1, 32'h8};
    tbl[7]  = '{0, 32'h0,   0, 1, 0, 32'h0,          1, 32'hBBBB_0004, 32'h4,   1, 32'h8};
    tbl[8]  = '{1, 32'h103, 0, 1, 0, 32'h0,          1, 32'hBBBB_0004, 32'h4,   0, 32'hC};
    tbl[9]  = '{0, 32'h0,   0, 1, 0, 32'h0,          0, NOP,           32'h0,   0, 32'h100};
    tbl[10] = '{0, 32'h0,   0, 1, 1, 32'hDEAD_0008,  0, NOP,           32'h0,   0, 32'h100};
    tbl[11] = '{0, 32'h0,   0, 1, 0, 32'h0,          0, NOP,           32'h0,   1, 32'h100};
    tbl[12] = '{1, 32'h200, 0, 1, 1, 32'hCCCC_0100,  0, NOP,           32'h0,   0, 32'h104};
    tbl[13] = '{1, 32'h301, 0, 1, 0, 32'h0,          0, NOP,           32'h0,   0, 32'h200};
    tbl[14] = '{0, 32'h0,   0, 1, 0, 32'h0,          0, NOP,           32'h0,   1, 32'h300};
    tbl[15] = '{0, 32'h0,   0, 1, 1, 32'hEEEE_0300,  0, NOP,           32'h0,   0, 32'h304};
    tbl[16] = '{0, 32'h0,   1, 0, 0, 32'h0,          1, 32'hEEEE_0300, 32'h300, 1, 32'h304};
    tbl[17] = '{0, 32'h0,   1, 0, 1, 32'h0BAD_0BAD,  0, NOP,           32'h0,   1, 32'h304};
    tbl[18] = '{0, 32'h0,   1, 0, 0, 32'h0,          0, NOP,           32'h0,   1, 32'h304};

    rst = 1'b1; PCSrc_i = 1'b0; PCTarget_i = '0; ready_i = 1'b0;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("por");

    // Cycle-exact vectors with directly driven memory signals
    foreach (tbl[i]) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      PCSrc_i = tbl[i].pcsrc; PCTarget_i = tbl[i].tgt; ready_i = tbl[i].rdy;
      imem_ready_i = tbl[i].mrdy; imem_rvalid_i = tbl[i].rv; imem_rdata_i = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d_valid", i), 32'(valid_o), 32'(tbl[i].valid));
      chk($sformatf("row%0d_instr", i), instr_o, tbl[i].instr);
      chk($sformatf("row%0d_pc", i), pc_o, tbl[i].pc);
      chk($sformatf("row%0d_pcplus4", i), pcplus4_o, tbl[i].pc + 32'd4);
      chk($sformatf("row%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i), imem_addr_o, tbl[i].addr);
    end

    // Startup from reset with one-cycle memory
    t_rst = 1; t_ready = 1; m_ready = 1; m_lat = 1; m_busy = 0;
    run_cycle(); chk_reset_outputs("rst1");
    run_cycle(); chk_reset_outputs("rst2");
    t_rst = 0;
    pops.delete();
    collect(4, "startup");
    for (int k = 0; k < 4; k++) chk_pop(k, 32'(4 * k), $sformatf("startup%0d", k));

    // Backpressure: fill the buffer, then drain with memory stalled
    t_ready = 0;
    repeat (10) run_cycle();
    chk("bp_full_req", 32'(imem_req_o), 32'd0);
    chk("bp_full_valid", 32'(valid_o), 32'd1);
    m_ready = 0; t_ready = 1; pops.delete();
    repeat (6) run_cycle();
    chk("bp_drained", 32'(pops.size()), 32'd2);
    chk_pop(0, 32'd16, "bp0");
    chk_pop(1, 32'd20, "bp1");
    m_ready = 1; pops.delete();
    collect(2, "bp_resume");
    chk_pop(0, 32'd24, "bp2");
    chk_pop(1, 32'd28, "bp3");

    // Redirect while a 3-cycle read is outstanding
    m_lat = 3;
    for (int c = 0; c < 20 && !(m_busy && m_cnt == 3); c++) run_cycle();
    chk("redir_wait_seen", 32'(m_busy && m_cnt == 3), 32'd1);
    pops.delete();
    t_pcsrc = 1; t_target = 32'h0000_0402;
    run_cycle();
    t_pcsrc = 0;
    collect(3, "redir");
    for (int k = 0; k < 3; k++) chk_pop(k, 32'h400 + 32'(4 * k), $sformatf("redir%0d", k));

    // PC wrap-around at the top of the address space
    m_lat = 1; pops.delete();
    t_pcsrc = 1; t_target = 32'hFFFF_FFF8;
    run_cycle();
    t_pcsrc = 0;
    collect(3, "wrap");
    chk_pop(0, 32'hFFFF_FFF8, "wrap0");
    chk_pop(1, 32'hFFFF_FFFC, "wrap1");
    chk_pop(2, 32'h0000_0000, "wrap2");

    // Asynchronous reset in WAIT; the stale response then lands in FETCH
    m_lat = 3;
    for (int c = 0; c < 20 && !(m_busy && m_cnt == 3); c++) run_cycle();
    chk("arst_wait_seen", 32'(m_busy && m_cnt == 3), 32'd1);
    run_cycle();
    #2 rst = 1'b1;
    #1 chk_reset_outputs("arst_now");
    t_rst = 1; m_ready = 0;
    run_cycle();
    t_rst = 0;
    run_cycle();
    chk("arst_stale_rvalid", 32'(imem_rvalid_i), 32'd1);
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      chk($sformatf("arst_ignored%0d_valid", k), 32'(valid_o), 32'd0);
      chk($sformatf("arst_ignored%0d_addr", k), imem_addr_o, 32'd0);
    end
    m_lat = 1; m_ready = 1; pops.delete();
    collect(2, "arst_resume");
    chk_pop(0, 32'd0, "arst0");
    chk_pop(1, 32'd4, "arst1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit that produces the instruction word the ControlUnit decodes and consumes the ControlUnit's branch decision (PCSrc). It holds the program counter, issues one read at a time to instruction memory over a request/response handshake, and buffers returned words in a small FIFO. It presents them downstream with a valid/ready handshake and flushes on a taken branch.

## Interface
- INSTR_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC / memory address width
- RESET_PC, 0, PC value loaded on reset
- DEPTH, 2, fetch buffer entries (power of two, ≥2)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- PCSrc_i  in  1  taken-branch/jump redirect from ControlUnit
- PCTarget_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (treated as 00)
- ready_i  in  1  downstream accepts instr_o this cycle
- valid_o  out  1  instr_o/pc_o/pcplus4_o hold a valid fetched instruction
- instr_o  out  INSTR_WIDTH  instruction at buffer head; 32'h00000013 (NOP) when valid_o=0
- pc_o  out  ADDR_WIDTH  address of instr_o; 0 when valid_o=0
- pcplus4_o  out  ADDR_WIDTH  pc_o+4, wraps modulo 2^ADDR_WIDTH
- imem_req_o  out  1  read request
- imem_addr_o  out  ADDR_WIDTH  read address (= fetch PC)
- imem_ready_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  read data returned
- imem_rdata_i  in  INSTR_WIDTH  read data

## Operation
- Registers: fetch_pc, req_pc (address of outstanding read), FIFO of {pc, instr} with count 0..DEPTH, state.
- States: FETCH (no read outstanding), WAIT (one read outstanding, result kept), DISCARD (one read outstanding, result dropped).
- FETCH: imem_req_o = (count < DEPTH) & ~PCSrc_i. On imem_req_o & imem_ready_i: req_pc <= fetch_pc, fetch_pc <= fetch_pc+4, go WAIT.
- WAIT: imem_req_o=0. On imem_rvalid_i: push {req_pc, imem_rdata_i}, go FETCH.
- DISCARD: imem_req_o=0. On imem_rvalid_i: drop data, go FETCH.
- Max one outstanding read. Space is checked at issue, so a push never overflows.
- Pop: valid_o & ready_i removes the head. Push and pop can occur in the same cycle, and count is then unchanged.
- Redirect (PCSrc_i=1 in a cycle):
  - FIFO flushed (count <= 0); any same-cycle push or pop is cancelled.
  - fetch_pc <= {PCTarget_i[ADDR_WIDTH-1:2], 2'b00}.
  - No new request is issued that cycle.
  - In WAIT without rvalid: go DISCARD. In WAIT with rvalid: data dropped, go FETCH.
  - In DISCARD: stay DISCARD, or go FETCH if rvalid that cycle.
- imem_rvalid_i while in FETCH is a protocol error and is ignored.
- PC arithmetic wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC + 4 = 0).

## Timing
- Reset (async, while rst=1): state=FETCH, fetch_pc=RESET_PC, count=0.
  - Outputs during reset: valid_o=0, instr_o=NOP, pc_o=0, imem_req_o=0 (forced while rst=1), imem_addr_o=RESET_PC.
- First request is in the first cycle after rst deasserts.
- Memory returns rvalid no earlier than the cycle after acceptance.
- valid_o rises the cycle after the push.
- Best case, zero-wait memory: request in cycle N, rvalid in N+1, valid_o in N+2. Steady throughput is one instruction per 2 cycles.
- Redirect in cycle N with nothing outstanding: imem_addr_o=target with req in N+1.
- Redirect with a read outstanding: the new request goes out the cycle after the stale rvalid.
- Reset mid-operation discards the outstanding read. Any rvalid arriving after reset while in FETCH is ignored.
- All outputs except imem_req_o are pure functions of registers. imem_req_o also depends on PCSrc_i.

## Test plan
- Reset/startup: RESET_PC=0, memory returns instr=PC-tagged words with 1-cycle latency -> pc_o sequence 0,4,8,12 with matching instr_o; valid_o=0 and instr_o=NOP throughout reset.
- Backpressure: ready_i=0 for 10 cycles -> exactly DEPTH=2 entries buffered, imem_req_o=0 while full, no lost or duplicated PCs after ready_i returns to 1.
- Redirect idle: PCSrc_i=1, PCTarget_i=0x103 while in FETCH with 2 buffered -> valid_o=0 next cycle, next imem_addr_o=0x100, next pc_o=0x100.
- Redirect with outstanding read: PCSrc_i=1 in WAIT, memory latency 3 -> stale word never appears on instr_o; first delivered pc_o=target.
- Simultaneous redirect and rvalid: same cycle -> data dropped, state FETCH, request to target next cycle.
- Wrap and async reset: PC 0xFFFFFFFC -> next fetch address 0x0, pcplus4_o=0x0; rst asserted mid-WAIT -> outputs at reset values immediately (before the next clock edge).
